// File: rtl/ps2_cmd_seq.sv
// PS/2 host command sequencer: send a byte, await ACK/RESEND/ERROR, forward unsolicited bytes.
// Latency: cmd_done and evt_valid are registered, one cycle after the deciding event; optional start-up reset sequence when PS2_CMD_SEQ_INIT_EN is defined.
// Backpressure: one command at a time; cmd_ready low while busy, bs_tx_valid held until bs_tx_consume.
module ps2_cmd_seq #(
  parameter int CLK_RATE   = 50000000,
  parameter int TIMEOUT_US = 20000,
  parameter int MAX_RETRY  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       cmd_done,
  output logic [1:0] cmd_status,
  output logic [7:0] evt_data,
  output logic       evt_valid,
  output logic       init_done,
  output logic [7:0] bs_tx_data,
  output logic       bs_tx_valid,
  input  logic       bs_tx_consume,
  input  logic [7:0] bs_rx_data,
  input  logic       bs_rx_produce
);

  localparam int TMO_RAW     = CLK_RATE / 1000000 * TIMEOUT_US;
  localparam int TIMEOUT_CYC = (TMO_RAW < 1) ? 1 : TMO_RAW;
  localparam int TMR_W       = $clog2(TIMEOUT_CYC + 1);
  localparam int RTY_W       = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_ERROR  = 8'hFC;

  localparam logic [1:0] ST_ACK   = 2'b00;
  localparam logic [1:0] ST_RETRY = 2'b01;
  localparam logic [1:0] ST_TMO   = 2'b10;
  localparam logic [1:0] ST_ERR   = 2'b11;

`ifdef PS2_CMD_SEQ_INIT_EN
  localparam logic [7:0] CMD_RESET = 8'hFF;
  localparam logic [7:0] BAT_OK    = 8'hAA;
  typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, INIT_SEND, INIT_ACK, INIT_BAT} state_t;
  localparam state_t RST_STATE = INIT_SEND;
`else
  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_t;
  localparam state_t RST_STATE = IDLE;
`endif

  state_t             state_q, state_nxt, resend_st;
  logic [7:0]         tx_dat_q, tx_dat_nxt;
  logic               tx_vld_q, tx_vld_nxt;
  logic [RTY_W-1:0]   retry_q, retry_nxt;
  logic [TMR_W-1:0]   timer_q, timer_nxt;
  logic [1:0]         status_q, status_nxt, fin_status;
  logic               done_q, done_nxt;
  logic               init_q, init_nxt;
  logic               evt_vld_q;
  logic [7:0]         evt_dat_q;
  logic               fin, rsp_taken, waiting;
  logic [7:0]         good_byte;

  always_comb begin
    state_nxt  = state_q;
    tx_dat_nxt = tx_dat_q;
    retry_nxt  = retry_q;
    timer_nxt  = timer_q;
    status_nxt = status_q;
    done_nxt   = 1'b0;
    fin        = 1'b0;
    fin_status = ST_ACK;
    rsp_taken  = 1'b0;
    waiting    = 1'b0;
    good_byte  = RSP_ACK;
    resend_st  = SEND;
`ifdef PS2_CMD_SEQ_INIT_EN
    init_nxt   = init_q;
`else
    init_nxt   = 1'b1;
`endif

    case (state_q)
      IDLE: if (cmd_valid) begin
        state_nxt  = SEND;
        tx_dat_nxt = cmd_data;
        retry_nxt  = '0;
      end
      SEND: if (tx_vld_q && bs_tx_consume) begin
        state_nxt = WAIT_ACK;
        timer_nxt = '0;
      end
      WAIT_ACK: waiting = 1'b1;
`ifdef PS2_CMD_SEQ_INIT_EN
      INIT_SEND: begin
        tx_dat_nxt = CMD_RESET;
        if (tx_vld_q && bs_tx_consume) begin
          state_nxt = INIT_ACK;
          timer_nxt = '0;
        end
      end
      INIT_ACK: begin
        waiting   = 1'b1;
        resend_st = INIT_SEND;
      end
      INIT_BAT: begin
        waiting   = 1'b1;
        resend_st = INIT_SEND;
        good_byte = BAT_OK;
      end
`endif
      default: state_nxt = RST_STATE;
    endcase

    // Response bytes win over a timeout landing in the same cycle.
    if (waiting) begin
      timer_nxt = timer_q + TMR_W'(1);
      if (bs_rx_produce && bs_rx_data == good_byte) begin
        rsp_taken = 1'b1;
        if (state_q == WAIT_ACK) begin
          fin        = 1'b1;
          fin_status = ST_ACK;
        end
`ifdef PS2_CMD_SEQ_INIT_EN
        else if (state_q == INIT_ACK) begin
          state_nxt = INIT_BAT;
          timer_nxt = '0;
        end else begin
          state_nxt = IDLE;
          init_nxt  = 1'b1;
        end
`endif
      end else if (bs_rx_produce && bs_rx_data == RSP_RESEND) begin
        rsp_taken = 1'b1;
        if (int'(retry_q) < MAX_RETRY) begin
          retry_nxt = retry_q + RTY_W'(1);
          state_nxt = resend_st;
        end else begin
          fin        = 1'b1;
          fin_status = ST_RETRY;
        end
      end else if (bs_rx_produce && bs_rx_data == RSP_ERROR) begin
        rsp_taken  = 1'b1;
        fin        = 1'b1;
        fin_status = ST_ERR;
      end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
        fin        = 1'b1;
        fin_status = ST_TMO;
      end
    end

    if (fin) begin
      state_nxt  = IDLE;
      done_nxt   = 1'b1;
      status_nxt = fin_status;
      init_nxt   = 1'b1;
    end

`ifdef PS2_CMD_SEQ_INIT_EN
    tx_vld_nxt = (state_nxt == SEND) || (state_nxt == INIT_SEND);
`else
    tx_vld_nxt = (state_nxt == SEND);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RST_STATE;
      tx_dat_q  <= '0;
      tx_vld_q  <= 1'b0;
      retry_q   <= '0;
      timer_q   <= '0;
      status_q  <= ST_ACK;
      done_q    <= 1'b0;
      init_q    <= 1'b0;
      evt_vld_q <= 1'b0;
      evt_dat_q <= '0;
    end else begin
      state_q   <= state_nxt;
      tx_dat_q  <= tx_dat_nxt;
      tx_vld_q  <= tx_vld_nxt;
      retry_q   <= retry_nxt;
      timer_q   <= timer_nxt;
      status_q  <= status_nxt;
      done_q    <= done_nxt;
      init_q    <= init_nxt;
      evt_vld_q <= bs_rx_produce && !rsp_taken;
      if (bs_rx_produce && !rsp_taken) evt_dat_q <= bs_rx_data;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign cmd_done    = done_q;
  assign cmd_status  = status_q;
  assign evt_valid   = evt_vld_q;
  assign evt_data    = evt_dat_q;
  assign init_done   = init_q;
  assign bs_tx_valid = tx_vld_q;
  assign bs_tx_data  = tx_dat_q;

endmodule
